// File: rtl/etapa_if_if.sv
// rtl/etapa_if_if.sv - fetch-stage signal bundle: control/redirect/loader inputs, PC and instruction outputs
interface etapa_if_if #(
    parameter int NBITS = 32
);
    logic             i_valid;
    logic             i_stall;
    logic             i_branch;
    logic [NBITS-1:0] i_branch_target;
    logic             i_jump;
    logic [NBITS-1:0] i_jump_target;
    logic             i_wr_en;
    logic [NBITS-1:0] i_wr_addr;
    logic [NBITS-1:0] i_wr_data;
    logic [NBITS-1:0] o_PC;
    logic [NBITS-1:0] o_PC4;
    logic [NBITS-1:0] o_PC8;
    logic [NBITS-1:0] o_Instruction;
    logic             o_halted;

    modport master (
        output i_valid, i_stall, i_branch, i_branch_target,
               i_jump, i_jump_target, i_wr_en, i_wr_addr, i_wr_data,
        input  o_PC, o_PC4, o_PC8, o_Instruction, o_halted
    );

    modport slave (
        input  i_valid, i_stall, i_branch, i_branch_target,
               i_jump, i_jump_target, i_wr_en, i_wr_addr, i_wr_data,
        output o_PC, o_PC4, o_PC8, o_Instruction, o_halted
    );
endinterface

// File: rtl/etapa_if.sv
// rtl/etapa_if.sv - instruction fetch stage: PC register, loadable instruction memory, RUN/HALTED control
module etapa_if #(
    parameter int               NBITS     = 32,
    parameter int               MEM_DEPTH = 256,
    parameter logic [NBITS-1:0] RESET_PC  = '0
) (
    input logic         i_clk,
    input logic         i_reset,
    etapa_if_if.slave   bus
);
    localparam int          AW        = $clog2(MEM_DEPTH);
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [NBITS-1:0] pc;
    logic [NBITS-1:0] pc_next;
    logic [NBITS-1:0] mem [MEM_DEPTH];
    logic [AW-1:0]    rd_idx;
    logic [AW-1:0]    wr_idx;
    logic [NBITS-1:0] fetched;
    logic             is_halt;
    logic             advance;

    assign rd_idx  = pc[AW+1:2];
    assign wr_idx  = bus.i_wr_addr[AW+1:2];
    assign fetched = mem[rd_idx];
    assign is_halt = (fetched == NBITS'(HALT_WORD));
    assign advance = bus.i_valid && !bus.i_stall;

    // Loader port is only live while the debug unit holds the pipeline frozen.
    always_ff @(posedge i_clk) begin
        if (bus.i_wr_en && !bus.i_valid) begin
            mem[wr_idx] <= bus.i_wr_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= RUN;
            pc    <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    // Stall outranks redirects; branch outranks jump since it belongs to the older instruction.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        if (state == RUN && advance) begin
            if (is_halt) begin
                state_next = HALTED;
            end else if (bus.i_branch) begin
                pc_next = {bus.i_branch_target[NBITS-1:2], 2'b00};
            end else if (bus.i_jump) begin
                pc_next = {bus.i_jump_target[NBITS-1:2], 2'b00};
            end else begin
                pc_next = pc + NBITS'(4);
            end
        end
    end

    assign bus.o_PC          = pc;
    assign bus.o_PC4         = pc + NBITS'(4);
    assign bus.o_PC8         = pc + NBITS'(8);
    assign bus.o_Instruction = (state == HALTED) ? '0 : fetched;
    assign bus.o_halted      = (state == HALTED);

    logic unused_bits;
    assign unused_bits = ^{bus.i_wr_addr[NBITS-1:AW+2], bus.i_wr_addr[1:0],
                           bus.i_branch_target[1:0], bus.i_jump_target[1:0]};
endmodule
